// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared writeback-stage FSM states, RISC-V load funct3 codes and
//            destination-register helpers.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    localparam logic [2:0] C_F3_LB  = 3'b000;
    localparam logic [2:0] C_F3_LH  = 3'b001;
    localparam logic [2:0] C_F3_LW  = 3'b010;
    localparam logic [2:0] C_F3_LBU = 3'b100;
    localparam logic [2:0] C_F3_LHU = 3'b101;

    localparam logic [4:0] C_RD_NONE = 5'd0;
    localparam logic [4:0] C_RD_RSVD = 5'd31;

    // x0 and x31 never receive a register-file write from this stage
    function automatic logic [4:0] wb_map_rd(input logic [4:0] rd);
        return (rd == C_RD_RSVD) ? C_RD_NONE : rd;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Selects the byte/halfword lane of a memory read word and sign- or
//            zero-extends it according to the RISC-V load funct3.
// Revision : 1.0  initial release
// ============================================================================
module load_extender
    import wb_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic [BITSIZE-1:0] mem_data_i,
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         addr_lsb_i,
    output logic [BITSIZE-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = mem_data_i[{addr_lsb_i, 3'b000} +: 8];
        // halfword accesses are aligned, so only the upper offset bit matters
        w_half = addr_lsb_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (funct3_i)
            C_F3_LB:  data_o = {{(BITSIZE-8){w_byte[7]}}, w_byte};
            C_F3_LH:  data_o = {{(BITSIZE-16){w_half[15]}}, w_half};
            C_F3_LBU: data_o = {{(BITSIZE-8){1'b0}}, w_byte};
            C_F3_LHU: data_o = {{(BITSIZE-16){1'b0}}, w_half};
            default:  data_o = mem_data_i;
        endcase
    end

endmodule : load_extender
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Pipeline writeback with load extension, register-file write port,
//            pending-write scoreboard and optional decode bypass
//            (enabled by defining WB_FORWARD_EN).
// Revision : 1.0  initial release
// ============================================================================
module writeback_stage
    import wb_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [4:0]         rd_i,
    input  logic [BITSIZE-1:0] result_i,
    input  logic               is_load_i,
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         addr_lsb_i,
    input  logic               mem_valid_i,
    input  logic [BITSIZE-1:0] mem_data_i,
    output logic [4:0]         rd_o,
    output logic [BITSIZE-1:0] data_rd_o,
    input  logic               issue_valid_i,
    input  logic [4:0]         issue_rd_i,
    output logic [31:0]        busy_o,
    output logic               fwd_valid_o,
    output logic [4:0]         fwd_rd_o,
    output logic [BITSIZE-1:0] fwd_data_o
);

    wb_state_e          state_q, state_d;
    logic [4:0]         rd_cap_q, rd_cap_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         lsb_q, lsb_d;
    logic [4:0]         rd_out_q, rd_out_d;
    logic [BITSIZE-1:0] data_out_q, data_out_d;
    logic [31:0]        busy_q, busy_d;
    logic [BITSIZE-1:0] w_ext_data;

    load_extender #(.BITSIZE(BITSIZE)) u_load_extender (
        .mem_data_i (mem_data_i),
        .funct3_i   (funct3_q),
        .addr_lsb_i (lsb_q),
        .data_o     (w_ext_data)
    );

    always_comb begin
        state_d    = state_q;
        rd_cap_d   = rd_cap_q;
        funct3_d   = funct3_q;
        lsb_d      = lsb_q;
        rd_out_d   = C_RD_NONE;
        data_out_d = '0;
        if (state_q == ST_WAIT_MEM) begin
            if (mem_valid_i) begin
                state_d    = ST_WRITE;
                rd_out_d   = rd_cap_q;
                data_out_d = w_ext_data;
            end
        end else if (valid_i) begin
            rd_cap_d = wb_map_rd(rd_i);
            if (is_load_i) begin
                state_d  = ST_WAIT_MEM;
                funct3_d = funct3_i;
                lsb_d    = addr_lsb_i;
            end else begin
                state_d    = ST_WRITE;
                rd_out_d   = wb_map_rd(rd_i);
                data_out_d = result_i;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // issue is applied after the writeback clear so a same-cycle reissue stays pending
    always_comb begin
        busy_d = busy_q;
        if (state_q == ST_WRITE) busy_d[rd_out_q] = 1'b0;
        if (issue_valid_i)       busy_d[issue_rd_i] = 1'b1;
        busy_d[0]  = 1'b0;
        busy_d[31] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rd_cap_q   <= '0;
            funct3_q   <= '0;
            lsb_q      <= '0;
            rd_out_q   <= '0;
            data_out_q <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_cap_q   <= rd_cap_d;
            funct3_q   <= funct3_d;
            lsb_q      <= lsb_d;
            rd_out_q   <= rd_out_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    assign ready_o   = (state_q != ST_WAIT_MEM);
    assign rd_o      = rd_out_q;
    assign data_rd_o = data_out_q;
    assign busy_o    = busy_q;

`ifdef WB_FORWARD_EN
    assign fwd_valid_o = (rd_out_q != C_RD_NONE);
    assign fwd_rd_o    = rd_out_q;
    assign fwd_data_o  = fwd_valid_o ? data_out_q : '0;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_rd_o    = 5'd0;
    assign fwd_data_o  = '0;
`endif

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, is_load_i, mem_valid_i, issue_valid_i;
    logic        ready_o, fwd_valid_o;
    logic [4:0]  rd_i, issue_rd_i, rd_o, fwd_rd_o;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lsb_i;
    logic [31:0] result_i, mem_data_i, data_rd_o, busy_o, fwd_data_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_busy = '0;
    logic [4:0]  exp_wr = '0;
    bit          rand_issue = 1'b0;

    always #5 clk = ~clk;

    writeback_stage #(.BITSIZE(32)) dut (
        .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .rd_i(rd_i), .result_i(result_i), .is_load_i(is_load_i),
        .funct3_i(funct3_i), .addr_lsb_i(addr_lsb_i),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .rd_o(rd_o), .data_rd_o(data_rd_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .busy_o(busy_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
    );

    // Expected load result derived from byte arithmetic on the memory word
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] w);
        longint unsigned v, b, h;
        v = w;
        b = (v >> (8 * lsb)) % 256;
        h = (v >> (16 * (lsb / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
            3'd1:    return (h >= 32768) ? (32'(h) | 32'hFFFF_0000) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [4:0] ref_rd(input logic [4:0] rd);
        return (rd == 5'd31) ? 5'd0 : rd;
    endfunction

    function automatic logic ref_fwd(input logic [4:0] rd);
`ifdef WB_FORWARD_EN
        return rd != 5'd0;
`else
        return (rd != rd) | 1'b0;
`endif
    endfunction

    // One clock: advance the scoreboard model, cross the edge, settle.
    task automatic step();
        if (rand_issue) begin
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_rd_i    = 5'($urandom);
        end
        if (exp_wr != 5'd0) m_busy[exp_wr] = 1'b0;
        if (issue_valid_i)  m_busy[issue_rd_i] = 1'b1;
        m_busy[0]  = 1'b0;
        m_busy[31] = 1'b0;
        @(posedge clk);
        #1;
        exp_wr = 5'd0;
        if (rand_issue) issue_valid_i = 1'b0;
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [31:0] val);
        logic [4:0] e_rd;
        total++;
        if (ready_o !== 1'b1) begin
            bad++; $display("FAIL alu_accept_ready: got %b exp 1", ready_o);
        end
        valid_i = 1'b1; is_load_i = 1'b0; rd_i = rd; result_i = val;
        mem_valid_i = 1'($urandom_range(0, 1)); mem_data_i = $urandom;
        step();
        valid_i = 1'b0; mem_valid_i = 1'b0;
        e_rd = ref_rd(rd);
        total++;
        if (rd_o !== e_rd || data_rd_o !== val || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL alu_write: got rd=%0d data=%h rdy=%b exp rd=%0d data=%h rdy=1",
                     rd_o, data_rd_o, ready_o, e_rd, val);
        end
        total++;
        if (fwd_valid_o !== ref_fwd(e_rd) || (ref_fwd(e_rd) && (fwd_rd_o !== e_rd || fwd_data_o !== val))) begin
            bad++;
            $display("FAIL alu_fwd: got v=%b rd=%0d data=%h exp v=%b rd=%0d data=%h",
                     fwd_valid_o, fwd_rd_o, fwd_data_o, ref_fwd(e_rd), e_rd, val);
        end
        total++;
        if (busy_o !== m_busy) begin
            bad++; $display("FAIL alu_busy: got %h exp %h", busy_o, m_busy);
        end
        exp_wr = e_rd;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                           input logic [31:0] w, input int waits);
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        valid_i = 1'b1; is_load_i = 1'b1; rd_i = rd; funct3_i = f3; addr_lsb_i = lsb;
        result_i = $urandom;
        step();
        valid_i = 1'b0;
        rd_i = 5'($urandom); funct3_i = 3'($urandom); addr_lsb_i = 2'($urandom);
        for (int i = 0; i <= waits; i++) begin
            total++;
            if (ready_o !== 1'b0 || rd_o !== 5'd0 || data_rd_o !== 32'd0) begin
                bad++;
                $display("FAIL load_wait[%0d]: got rdy=%b rd=%0d data=%h exp rdy=0 rd=0 data=0",
                         i, ready_o, rd_o, data_rd_o);
            end
            mem_valid_i = (i == waits);
            mem_data_i  = (i == waits) ? w : $urandom;
            step();
        end
        mem_valid_i = 1'b0; mem_data_i = $urandom;
        e_rd   = ref_rd(rd);
        e_data = ref_load(f3, lsb, w);
        total++;
        if (rd_o !== e_rd || data_rd_o !== e_data || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL load_write f3=%0d lsb=%0d: got rd=%0d data=%h rdy=%b exp rd=%0d data=%h rdy=1",
                     f3, lsb, rd_o, data_rd_o, ready_o, e_rd, e_data);
        end
        total++;
        if (fwd_valid_o !== ref_fwd(e_rd) || busy_o !== m_busy) begin
            bad++;
            $display("FAIL load_fwd_busy: got v=%b busy=%h exp v=%b busy=%h",
                     fwd_valid_o, busy_o, ref_fwd(e_rd), m_busy);
        end
        exp_wr = e_rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1; is_load_i = 1'b0; rd_i = 5'd5; result_i = $urandom;
        funct3_i = 3'd0; addr_lsb_i = 2'd0; mem_valid_i = 1'b1; mem_data_i = $urandom;
        issue_valid_i = 1'b1; issue_rd_i = 5'd4;
        step(); step();
        rst_i = 1'b0; valid_i = 1'b0; mem_valid_i = 1'b0; issue_valid_i = 1'b0;
        m_busy = '0; exp_wr = '0;
        total++;
        if (ready_o !== 1'b1 || rd_o !== 5'd0 || data_rd_o !== 32'd0 || busy_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b rd=%0d data=%h busy=%h exp 1/0/0/0",
                     ready_o, rd_o, data_rd_o, busy_o);
        end
        total++;
        if (fwd_valid_o !== 1'b0 || fwd_rd_o !== 5'd0 || fwd_data_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_fwd: got v=%b rd=%0d data=%h exp 0/0/0",
                     fwd_valid_o, fwd_rd_o, fwd_data_o);
        end
    endtask

    task automatic test_alu();
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        step();
        issue_valid_i = 1'b0;
        total++;
        if (busy_o[5] !== 1'b1) begin
            bad++; $display("FAIL alu_issue_busy5: got %b exp 1", busy_o[5]);
        end
        do_alu(5'd5, 32'h0000_1234);
        step();
        total++;
        if (rd_o !== 5'd0 || data_rd_o !== 32'd0 || busy_o[5] !== 1'b0) begin
            bad++;
            $display("FAIL alu_after: got rd=%0d data=%h busy5=%b exp 0/0/0",
                     rd_o, data_rd_o, busy_o[5]);
        end
    endtask

    task automatic test_loads();
        do_load(5'd3, 3'b000, 2'd2, 32'h0080_0000, 2);
        total++;
        if (data_rd_o !== 32'hFFFF_FF80) begin
            bad++; $display("FAIL lb_value: got %h exp ffffff80", data_rd_o);
        end
        do_load(5'd4, 3'b101, 2'd2, 32'h8001_ABCD, 0);
        total++;
        if (data_rd_o !== 32'h0000_8001) begin
            bad++; $display("FAIL lhu_value: got %h exp 00008001", data_rd_o);
        end
        do_load(5'd6, 3'b001, 2'd2, 32'h8001_ABCD, 1);
        total++;
        if (data_rd_o !== 32'hFFFF_8001) begin
            bad++; $display("FAIL lh_value: got %h exp ffff8001", data_rd_o);
        end
        do_load(5'd8,  3'b011, 2'd1, 32'hDEAD_BEEF, 0);
        do_load(5'd9,  3'b110, 2'd3, 32'h1357_9BDF, 0);
        do_load(5'd31, 3'b111, 2'd0, 32'hCAFE_F00D, 0);
        do_load(5'd10, 3'b100, 2'd3, 32'hF100_0000, 0);
        step();
    endtask

    task automatic test_ignore_mem();
        mem_valid_i = 1'b1; mem_data_i = 32'hA5A5_A5A5;
        step();
        step();
        mem_valid_i = 1'b0;
        total++;
        if (rd_o !== 5'd0 || data_rd_o !== 32'd0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ignore_mem: got rd=%0d data=%h rdy=%b exp 0/0/1",
                     rd_o, data_rd_o, ready_o);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        issue_valid_i = 1'b0;
        do_alu(5'd7, 32'h0000_0077);
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        total++;
        if (busy_o[7] !== 1'b1) begin
            bad++; $display("FAIL sb_set_wins: got busy7=%b exp 1", busy_o[7]);
        end
        issue_rd_i = 5'd0;
        step();
        total++;
        if (busy_o[0] !== 1'b0) begin
            bad++; $display("FAIL sb_x0: got busy0=%b exp 0", busy_o[0]);
        end
        issue_rd_i = 5'd31;
        step();
        issue_valid_i = 1'b0;
        total++;
        if (busy_o[31] !== 1'b0 || busy_o !== m_busy) begin
            bad++; $display("FAIL sb_x31: got busy=%h exp %h", busy_o, m_busy);
        end
        do_alu(5'd7, 32'h0000_0007);
        step();
        total++;
        if (busy_o[7] !== 1'b0) begin
            bad++; $display("FAIL sb_clear: got busy7=%b exp 0", busy_o[7]);
        end
    endtask

    task automatic test_reset_mid_load();
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        valid_i = 1'b1; is_load_i = 1'b1; rd_i = 5'd10; funct3_i = 3'b010; addr_lsb_i = 2'd0;
        step();
        valid_i = 1'b0;
        total++;
        if (ready_o !== 1'b0 || busy_o[9] !== 1'b1) begin
            bad++; $display("FAIL rml_pre: got rdy=%b busy9=%b exp 0/1", ready_o, busy_o[9]);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; m_busy = '0;
        mem_valid_i = 1'b1; mem_data_i = 32'h1234_5678;
        step();
        mem_valid_i = 1'b0;
        total++;
        if (rd_o !== 5'd0 || data_rd_o !== 32'd0 || busy_o !== 32'd0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rml_post: got rd=%0d data=%h busy=%h rdy=%b exp 0/0/0/1",
                     rd_o, data_rd_o, busy_o, ready_o);
        end
        step();
        total++;
        if (rd_o !== 5'd0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL rml_idle: got rd=%0d rdy=%b exp 0/1", rd_o, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        do_alu(5'd1, 32'h1111_1111);
        do_alu(5'd2, 32'h2222_2222);
        step();
        total++;
        if (rd_o !== 5'd0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL b2b_end: got rd=%0d rdy=%b exp 0/1", rd_o, ready_o);
        end
    endtask

    task automatic test_random();
        rand_issue = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0: do_alu(5'($urandom), $urandom);
                1: do_load(5'($urandom), 3'($urandom), 2'($urandom), $urandom,
                           int'($urandom_range(0, 3)));
                default: begin
                    step();
                    total++;
                    if (rd_o !== 5'd0 || fwd_valid_o !== 1'b0 || busy_o !== m_busy) begin
                        bad++;
                        $display("FAIL rand_idle: got rd=%0d fv=%b busy=%h exp 0/0/%h",
                                 rd_o, fwd_valid_o, busy_o, m_busy);
                    end
                end
            endcase
        end
        step();
        rand_issue = 1'b0;
        issue_valid_i = 1'b0;
    endtask

    initial begin
        valid_i = 1'b0; is_load_i = 1'b0; mem_valid_i = 1'b0; issue_valid_i = 1'b0;
        rd_i = '0; issue_rd_i = '0; funct3_i = '0; addr_lsb_i = '0;
        result_i = '0; mem_data_i = '0; rst_i = 1'b1;
        test_reset();
        test_alu();
        test_loads();
        test_ignore_mem();
        test_scoreboard();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter BITSIZE, default 32, meaning datapath and register width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  the memory stage presents an instruction.
REQ-005 SHALL have port ready_o  output  1  the stage accepts the presented instruction.
REQ-006 SHALL have ports rd_i input 5, result_i input BITSIZE, is_load_i input 1, funct3_i input 3, addr_lsb_i input 2: destination register, ALU result, load flag, RISC-V load type, byte offset.
REQ-007 SHALL have ports mem_valid_i input 1 and mem_data_i input BITSIZE: memory read response word.
REQ-008 SHALL have ports rd_o output 5 and data_rd_o output BITSIZE: register-file write port; rd_o=0 means no write.
REQ-009 SHALL have ports issue_valid_i input 1 and issue_rd_i input 5: decode issues an instruction writing issue_rd_i.
REQ-010 SHALL have port busy_o output 32: per-register pending-write scoreboard.
REQ-011 SHALL have ports fwd_valid_o output 1, fwd_rd_o output 5, fwd_data_o output BITSIZE: bypass to decode.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_MEM, WRITE.
REQ-013 SHALL drive ready_o=1 in IDLE and WRITE, and ready_o=0 in WAIT_MEM.
REQ-014 SHALL, on acceptance with is_load_i=0, register rd_i/result_i and enter WRITE; the write appears on rd_o/data_rd_o the next cycle for exactly one cycle.
REQ-015 SHALL, on acceptance with is_load_i=1, register rd_i/funct3_i/addr_lsb_i and enter WAIT_MEM; mem_valid_i sampled at or after the following edge moves the FSM to WRITE with the extended data.
REQ-016 SHALL accept a new instruction in WRITE (back-to-back), going to WRITE or WAIT_MEM; with no new instruction it returns to IDLE.
REQ-017 SHALL extend loads per funct3: LB=000 and LH=001 sign-extend, LW=010 passes the word, LBU=100 and LHU=101 zero-extend; the lane is selected by addr_lsb_i, and LH/LHU use bit 1 only.
REQ-018 SHALL treat funct3 values 011, 110 and 111 as LW.
REQ-019 SHALL drive rd_o=0 and data_rd_o=0 in every non-WRITE cycle; rd_i of 0 or 31 in WRITE yields rd_o=0.
REQ-020 SHALL set busy_o[issue_rd_i] on issue_valid_i, and clear busy_o[rd_o] in the WRITE cycle; when both hit one register in the same cycle, set wins.
REQ-021 SHALL hold busy_o[0] and busy_o[31] at 0 permanently.
REQ-022 SHALL ignore mem_valid_i outside WAIT_MEM.

Reset
REQ-023 SHALL, with rst_i high at an edge, enter IDLE, clear busy_o, and zero rd_o, data_rd_o, fwd_*_o and all captured fields; ready_o is 1 the cycle after reset.
REQ-024 SHALL, when reset arrives in WAIT_MEM, drop the pending load without any write.

Configuration
REQ-025 SHALL, with WB_FORWARD_EN defined, drive fwd_valid_o=1 and fwd_rd_o=rd_o, fwd_data_o=data_rd_o whenever rd_o is nonzero; otherwise fwd_valid_o=0.
REQ-026 SHALL, without WB_FORWARD_EN, keep the fwd ports present and tied to 0.

Structure
REQ-027 SHALL place the FSM state enum and the funct3 load constants in shared package wb_pkg.
REQ-028 SHALL implement load lane select and extension in combinational sub-module load_extender.

Verification
REQ-029 SHALL cover an ALU write: valid_i=1, rd_i=5, result_i=0x1234, is_load_i=0 -> the next cycle rd_o=5, data_rd_o=0x1234, busy_o[5] cleared; the cycle after, rd_o=0.
REQ-030 SHALL cover LB: funct3=000, addr_lsb=2, mem_data=0x00800000 after 3 wait cycles -> ready_o=0 for 3 cycles, then data_rd_o=0xFFFFFF80.
REQ-031 SHALL cover LHU: addr_lsb=2, mem_data=0x8001ABCD -> data_rd_o=0x00008001; LH on the same input -> 0xFFFF8001.
REQ-032 SHALL cover the scoreboard: issue rd=7 in the same cycle as WRITE rd=7 -> busy_o[7]=1; issue rd=0 -> busy_o[0]=0.
REQ-033 SHALL cover reset mid-load: rst_i=1 in WAIT_MEM, then mem_valid_i=1 -> no write occurs, busy_o=0, FSM in IDLE.
REQ-034 SHALL cover back-to-back ALU writes to rd=1 then rd=2 -> rd_o=1 then rd_o=2 in consecutive cycles, with ready_o=1 throughout.
